// File: rtl/ifft_twiddle_seq.sv
// ifft_twiddle_seq: walks the real/imaginary twiddle ROM pair over one pass and
// re-times the 1-cycle-latency ROM words into a valid/ready beat stream.
// Optional build macro: TW_CONJ_EN -- emit conjugate twiddles (tw_im = -rom_im,
// with the most negative word saturating to the most positive one).
module ifft_twiddle_seq #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NUM_GROUPS = 7,
  parameter int unsigned GROUP_SIZE = 4,
  parameter int unsigned REPEAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_re,
  input  logic [DATA_W-1:0] rom_im,
  output logic              tw_valid,
  input  logic              tw_ready,
  output logic [DATA_W-1:0] tw_re,
  output logic [DATA_W-1:0] tw_im,
  output logic [ADDR_W-1:0] tw_idx,
  output logic              tw_last
);

  localparam int unsigned NUM_ADDR = NUM_GROUPS * GROUP_SIZE;
  localparam int unsigned REP_W    = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ADDR - 1);
  localparam logic [REP_W-1:0]  LAST_REP  = REP_W'(REPEAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  // Issue side
  logic [ADDR_W-1:0] next_addr;
  logic [REP_W-1:0]  rep_cnt;
  logic              issue_c;
  logic              issue_last_c;
  logic              busy_nx;
  logic              done_nx;

  // Read pipeline: p1 = address on the ROM bus, p2 = data on the ROM outputs
  logic              p1_vld;
  logic              p1_last;
  logic              p2_vld;
  logic              p2_last;
  logic [ADDR_W-1:0] p2_idx;

  // Output register plus 2-entry skid FIFO behind it
  logic [DATA_W-1:0] fifo_re   [2];
  logic [DATA_W-1:0] fifo_im   [2];
  logic [ADDR_W-1:0] fifo_idx  [2];
  logic              fifo_last [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        buf_count;

  logic              pop_c;
  logic              load_c;
  logic              fifo_rd_c;
  logic              fifo_wr_c;
  logic [2:0]        occ_c;
  logic              credit_ok_c;
  logic [DATA_W-1:0] push_im_c;

  // Credit: every outstanding read must already own a slot (output reg + 2 FIFO)
  assign pop_c        = tw_valid & tw_ready;
  assign occ_c        = 3'(tw_valid) + 3'(buf_count) + 3'(p1_vld) + 3'(p2_vld);
  assign credit_ok_c  = (occ_c - 3'(pop_c)) < 3'd3;
  assign issue_last_c = (next_addr == LAST_ADDR) && (rep_cnt == LAST_REP);

  // Optional conjugation of the imaginary part at push time
`ifdef TW_CONJ_EN
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};
  assign push_im_c = (rom_im == MOST_NEG) ? MOST_POS : (~rom_im + DATA_W'(1));
`else
  assign push_im_c = rom_im;
`endif

  assign load_c    = !tw_valid || pop_c;
  assign fifo_rd_c = load_c && (buf_count != 2'd0);
  assign fifo_wr_c = p2_vld && !(load_c && (buf_count == 2'd0));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = issue_last_c ? S_DRAIN : S_RUN;
      S_RUN:   if (credit_ok_c && issue_last_c) state_nx = S_DRAIN;
      S_DRAIN: if (pop_c && tw_last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM outputs: issue strobe and next busy/done values
  always_comb begin
    issue_c = 1'b0;
    busy_nx = 1'b0;
    done_nx = 1'b0;
    case (state)
      S_IDLE:  issue_c = start;
      S_RUN:   issue_c = credit_ok_c;
      default: issue_c = 1'b0;
    endcase
    busy_nx = (state_nx == S_RUN) || (state_nx == S_DRAIN);
    done_nx = (state_nx == S_DONE);
  end

  // Registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nx;
      done <= done_nx;
    end
  end

  // Address issue: each address issued REPEAT times, rom_addr holds when stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr  <= '0;
      next_addr <= '0;
      rep_cnt   <= '0;
      p1_vld    <= 1'b0;
      p1_last   <= 1'b0;
    end else begin
      p1_vld <= issue_c;
      if (issue_c) begin
        rom_addr <= next_addr;
        p1_last  <= issue_last_c;
        if (rep_cnt == LAST_REP) begin
          rep_cnt   <= '0;
          next_addr <= next_addr + ADDR_W'(1);
        end else begin
          rep_cnt <= rep_cnt + REP_W'(1);
        end
      end
      if (state == S_DONE) begin
        next_addr <= '0;
        rep_cnt   <= '0;
      end
    end
  end

  // Track which address the ROM outputs currently belong to
  always_ff @(posedge clk) begin
    if (rst) begin
      p2_vld  <= 1'b0;
      p2_last <= 1'b0;
      p2_idx  <= '0;
    end else begin
      p2_vld  <= p1_vld;
      p2_last <= p1_last;
      p2_idx  <= rom_addr;
    end
  end

  // Output register fed from the FIFO head, or straight from the ROM when empty
  always_ff @(posedge clk) begin
    if (rst) begin
      tw_valid  <= 1'b0;
      tw_re     <= '0;
      tw_im     <= '0;
      tw_idx    <= '0;
      tw_last   <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      buf_count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_re[i]   <= '0;
        fifo_im[i]   <= '0;
        fifo_idx[i]  <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if (load_c) begin
        if (buf_count != 2'd0) begin
          tw_valid <= 1'b1;
          tw_re    <= fifo_re[rd_ptr];
          tw_im    <= fifo_im[rd_ptr];
          tw_idx   <= fifo_idx[rd_ptr];
          tw_last  <= fifo_last[rd_ptr];
        end else if (p2_vld) begin
          tw_valid <= 1'b1;
          tw_re    <= rom_re;
          tw_im    <= push_im_c;
          tw_idx   <= p2_idx;
          tw_last  <= p2_last;
        end else begin
          tw_valid <= 1'b0;
          tw_last  <= 1'b0;
        end
      end
      if (fifo_wr_c) begin
        fifo_re[wr_ptr]   <= rom_re;
        fifo_im[wr_ptr]   <= push_im_c;
        fifo_idx[wr_ptr]  <= p2_idx;
        fifo_last[wr_ptr] <= p2_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (fifo_rd_c) rd_ptr <= ~rd_ptr;
      buf_count <= buf_count + 2'(fifo_wr_c) - 2'(fifo_rd_c);
    end
  end

endmodule

// File: tb/tb_ifft_twiddle_seq.sv
// Bench for ifft_twiddle_seq: two instances (REPEAT=1 and REPEAT=2) driven by
// registered ROM models, checked against an expected-beat queue built from the table.
module tb_ifft_twiddle_seq;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 16;
  localparam int unsigned NADDR = 28;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic sel = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [DW-1:0] tbl_re [32];
  logic [DW-1:0] tbl_im [32];

  always #5 clk = ~clk;

  logic          start1, busy1, done1, valid1, last1;
  logic [AW-1:0] addr1, idx1;
  logic [DW-1:0] rre1, rim1, re1, im1;
  logic          start2, busy2, done2, valid2, last2;
  logic [AW-1:0] addr2, idx2;
  logic [DW-1:0] rre2, rim2, re2, im2;

  assign start1 = start & ~sel;
  assign start2 = start & sel;

  ifft_twiddle_seq #(.REPEAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .rom_addr(addr1), .rom_re(rre1), .rom_im(rim1),
    .tw_valid(valid1), .tw_ready(ready), .tw_re(re1), .tw_im(im1),
    .tw_idx(idx1), .tw_last(last1)
  );

  ifft_twiddle_seq #(.REPEAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .rom_addr(addr2), .rom_re(rre2), .rom_im(rim2),
    .tw_valid(valid2), .tw_ready(ready), .tw_re(re2), .tw_im(im2),
    .tw_idx(idx2), .tw_last(last2)
  );

  // Twiddle ROMs: registered read, no enable
  always @(posedge clk) begin
    rre1 <= tbl_re[addr1];
    rim1 <= tbl_im[addr1];
    rre2 <= tbl_re[addr2];
    rim2 <= tbl_im[addr2];
  end

  logic          m_busy, m_done, m_valid, m_last;
  logic [AW-1:0] m_addr, m_idx;
  logic [DW-1:0] m_re, m_im;
  logic [1:0]    m_buf;

  assign m_busy  = sel ? busy2  : busy1;
  assign m_done  = sel ? done2  : done1;
  assign m_valid = sel ? valid2 : valid1;
  assign m_last  = sel ? last2  : last1;
  assign m_addr  = sel ? addr2  : addr1;
  assign m_idx   = sel ? idx2   : idx1;
  assign m_re    = sel ? re2    : re1;
  assign m_im    = sel ? im2    : im1;
  assign m_buf   = sel ? dut2.buf_count : dut1.buf_count;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_im(input logic [DW-1:0] v);
`ifdef TW_CONJ_EN
    int signed n;
    n = -int'($signed(v));
    if (n > 32767) n = 32767;
    return DW'(n);
`else
    return v;
`endif
  endfunction

  function automatic logic pick(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  // One full pass with random/held ready, compared beat by beat against the table
  task automatic run_pass(input bit use2, input int pct, input int hold, input bit mid_start);
    beat_t         q[$];
    beat_t         b;
    beat_t         saved;
    int            rep;
    int            cyc;
    int            first_v;
    int            last_acc;
    int            accepted;
    bit            stall;
    bit            fin;
    logic [AW-1:0] hold_addr;
    rep = use2 ? 2 : 1;
    cyc = 0; first_v = 0; last_acc = -10; accepted = 0;
    stall = 1'b0; fin = 1'b0; hold_addr = '0; saved = '0;
    for (int a = 0; a < int'(NADDR); a++)
      for (int r = 0; r < rep; r++) begin
        b.idx  = AW'(a);
        b.re   = tbl_re[a];
        b.im   = model_im(tbl_im[a]);
        b.last = (a == int'(NADDR) - 1) && (r == rep - 1);
        q.push_back(b);
      end
    sel = use2;
    @(negedge clk);
    start = 1'b1;
    ready = (hold > 0) ? 1'b0 : pick(pct);
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = mid_start && (cyc == 6);
      if (m_valid && first_v == 0) first_v = cyc;
      if (cyc == 1) begin
        check_val("addr_first", 64'(m_addr), 64'(0));
        check_val("busy_first", 64'(m_busy), 64'(1));
      end
      check_val("buf_le2", 64'(m_buf <= 2'd2), 64'(1));
      if (stall) check_val("stall_stable", 64'({m_valid, m_idx, m_re, m_im, m_last}), 64'({1'b1, saved}));
      if (hold > 0 && cyc == 10) hold_addr = m_addr;
      if (hold > 0 && cyc > 10 && cyc < hold) check_val("addr_hold", 64'(m_addr), 64'(hold_addr));
      if (m_done) begin
        check_val("done_after_last", 64'(cyc - last_acc), 64'(1));
        check_val("beats_left", 64'(q.size()), 64'(0));
        check_val("busy_in_done", 64'(m_busy), 64'(0));
        fin = 1'b1;
      end
      ready = (cyc < hold) ? 1'b0 : pick(pct);
      stall = m_valid && !ready;
      saved = {m_idx, m_re, m_im, m_last};
      if (m_valid && ready) begin
        accepted++;
        last_acc = cyc;
        if (q.size() == 0) begin
          check_val("beat_count", 64'(accepted), 64'(NADDR * rep));
        end else begin
          b = q.pop_front();
          check_val("idx",  64'(m_idx),  64'(b.idx));
          check_val("re",   64'(m_re),   64'(b.re));
          check_val("im",   64'(m_im),   64'(b.im));
          check_val("last", 64'(m_last), 64'(b.last));
`ifdef TW_CONJ_EN
          if (b.idx == 5'd5)  check_val("idx5_im",  64'(m_im), 64'(16'hFF00));
          if (b.idx == 5'd9)  check_val("idx9_im",  64'(m_im), 64'(16'hFF4B));
          if (b.idx == 5'd13) check_val("idx13_im", 64'(m_im), 64'(16'h7FFF));
`else
          if (b.idx == 5'd5)  check_val("idx5_im",  64'(m_im), 64'(16'h0100));
          if (b.idx == 5'd9)  check_val("idx9_im",  64'(m_im), 64'(16'h00B5));
          if (b.idx == 5'd13) check_val("idx13_im", 64'(m_im), 64'(16'h8000));
`endif
        end
      end
    end
    check_val("pass_done", 64'(fin), 64'(1));
    if (pct == 100 && hold == 0) check_val("first_valid_cycle", 64'(first_v), 64'(3));
    @(negedge clk);
    check_val("done_pulse_end", 64'({m_done, m_busy, m_valid}), 64'(0));
    ready = 1'b0;
  endtask

  // Reset in the middle of a pass: everything clears, no done pulse follows
  task automatic abort_test();
    int n;
    int cyc;
    n = 0; cyc = 0;
    sel = 1'b0;
    @(negedge clk);
    start = 1'b1;
    ready = 1'b1;
    while (n < 10 && cyc < 200) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (m_valid && ready) n++;
    end
    check_val("abort_reached", 64'(n), 64'(10));
    rst = 1'b1;
    @(negedge clk);
    check_val("abort_outputs",
              64'({busy1, done1, addr1, valid1, re1, im1, idx1, last1}), 64'(0));
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check_val("abort_quiet", 64'({m_busy, m_done, m_valid}), 64'(0));
    end
    ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      tbl_re[i] = DW'($urandom);
      tbl_im[i] = DW'($urandom);
    end
    tbl_im[5]  = 16'h0100;
    tbl_im[9]  = 16'h00B5;
    tbl_im[13] = 16'h8000;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("reset_idle1", 64'({busy1, done1, addr1, valid1, re1, im1, idx1, last1}), 64'(0));
      check_val("reset_idle2", 64'({busy2, done2, addr2, valid2, re2, im2, idx2, last2}), 64'(0));
    end
    run_pass(1'b0, 100, 0, 1'b0);
    run_pass(1'b0, 50, 0, 1'b0);
    run_pass(1'b0, 50, 0, 1'b1);
    run_pass(1'b0, 100, 30, 1'b0);
    run_pass(1'b1, 100, 0, 1'b0);
    run_pass(1'b1, 60, 0, 1'b1);
    abort_test();
    run_pass(1'b0, 100, 0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
